// File: rtl/memory_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack data bus. Optional bus timeout under MEM_STAGE_TIMEOUT_EN.
// Latency: 1 cycle for non-memory and misaligned ops; memory ops hold the stage until ack, then present the result one cycle later.
// Backpressure: ready_out is high only in IDLE, and a bundle offered while busy is not taken.
module memory_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       store_data_in,
    input  logic [31:0]       instruction_bits_in,
    input  logic [4:0]        rd_in,
    input  logic              rd_valid_in,
    input  logic [31:0]       program_counter_in,
    input  logic [31:0]       next_program_counter_in,
    input  logic              done_in,
    output logic              dmem_req_out,
    output logic              dmem_we_out,
    output logic [ADDR_W-1:0] dmem_addr_out,
    output logic [3:0]        dmem_be_out,
    output logic [31:0]       dmem_wdata_out,
    input  logic [31:0]       dmem_rdata_in,
    input  logic              dmem_ack_in,
    output logic              wb_valid_out,
    output logic [31:0]       rd_data_out,
    output logic [31:0]       source_data_out,
    output logic [31:0]       instruction_bits_out,
    output logic [31:0]       program_counter_out,
    output logic [31:0]       next_program_counter_out,
    output logic [4:0]        rd_out,
    output logic              rd_valid_out,
    output logic              done_out,
    output logic              misaligned_out,
    output logic              bus_error_out
);
    localparam logic [31:0] NOP      = 32'h11111111;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] src;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic        rd_valid;
        logic        done;
        logic        we;
        logic [2:0]  f3;
        logic [3:0]  be;
        logic [31:0] wdata;
    } hold_t;

    typedef struct packed {
        logic [31:0] rd_data;
        logic [31:0] src;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic        rd_valid;
        logic        done;
    } wb_t;

    state_t state_q, state_d;
    hold_t  hold_q, hold_d;
    wb_t    out_q, out_d;
    logic   wb_vld_q, wb_vld_d;
    logic   mis_q, mis_d;
    logic   berr_q, berr_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  a_in;
    logic        is_load, is_store, is_mem, misal;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        timeout;

    // Decode of the incoming bundle: access size comes from funct3[1:0].
    always_comb begin
        opcode   = instruction_bits_in[6:0];
        funct3   = instruction_bits_in[14:12];
        a_in     = alu_result_in[1:0];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_mem   = is_load | is_store;
        misal    = 1'b0;
        be_in    = 4'b1111;
        wdata_in = store_data_in;
        case (funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << a_in;
                wdata_in = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                misal    = a_in[0];
                be_in    = a_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data_in[15:0]}};
            end
            default: misal = (a_in != 2'b00);
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata_in[7:0];
        case (hold_q.alu[1:0])
            2'd1:    ld_byte = dmem_rdata_in[15:8];
            2'd2:    ld_byte = dmem_rdata_in[23:16];
            2'd3:    ld_byte = dmem_rdata_in[31:24];
            default: ld_byte = dmem_rdata_in[7:0];
        endcase
        ld_half = hold_q.alu[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (hold_q.f3[1:0])
            2'b00:   ld_val = hold_q.f3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = hold_q.f3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = dmem_rdata_in;
        endcase
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d   = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
    assign timeout = (state_q == ACCESS) && !dmem_ack_in
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    // Without the timeout feature ACCESS waits for ack indefinitely.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_d.instr  = NOP;
        out_d.rd_valid = 1'b0;
        wb_vld_d     = 1'b0;
        mis_d        = 1'b0;
        berr_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_mem && !misal) begin
                        hold_d = '{alu: alu_result_in, src: store_data_in,
                                   instr: instruction_bits_in, pc: program_counter_in,
                                   npc: next_program_counter_in, rd: rd_in,
                                   rd_valid: rd_valid_in, done: done_in, we: is_store,
                                   f3: funct3, be: be_in, wdata: wdata_in};
                        state_d = ACCESS;
                    end else begin
                        wb_vld_d = 1'b1;
                        mis_d    = is_mem;
                        out_d    = '{rd_data: alu_result_in, src: store_data_in,
                                     instr: instruction_bits_in, pc: program_counter_in,
                                     npc: next_program_counter_in, rd: rd_in,
                                     rd_valid: rd_valid_in && !is_mem, done: done_in};
                    end
                end
            end
            ACCESS: begin
                // An ack in the timeout cycle wins; timeout already excludes it.
                if (dmem_ack_in || timeout) begin
                    state_d  = RESP;
                    wb_vld_d = 1'b1;
                    berr_d   = timeout;
                    out_d    = '{rd_data: timeout ? 32'b0 : (hold_q.we ? hold_q.alu : ld_val),
                                 src: hold_q.src, instr: hold_q.instr, pc: hold_q.pc,
                                 npc: hold_q.npc, rd: hold_q.rd,
                                 rd_valid: !timeout && !hold_q.we && hold_q.rd_valid,
                                 done: hold_q.done};
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            out_q       <= '0;
            out_q.instr <= NOP;
            wb_vld_q    <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            out_q    <= out_d;
            wb_vld_q <= wb_vld_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign ready_out      = (state_q == IDLE);
    // Reset gates the request combinationally so an in-flight access aborts in the reset cycle.
    assign dmem_req_out   = (state_q == ACCESS) && rst_n;
    assign dmem_we_out    = dmem_req_out && hold_q.we;
    assign dmem_addr_out  = {hold_q.alu[ADDR_W-1:2], 2'b00};
    assign dmem_be_out    = dmem_req_out ? hold_q.be : 4'b0000;
    assign dmem_wdata_out = hold_q.wdata;

    assign wb_valid_out             = wb_vld_q;
    assign rd_data_out              = out_q.rd_data;
    assign source_data_out          = out_q.src;
    assign instruction_bits_out     = out_q.instr;
    assign program_counter_out      = out_q.pc;
    assign next_program_counter_out = out_q.npc;
    assign rd_out                   = out_q.rd;
    assign rd_valid_out             = out_q.rd_valid;
    assign done_out                 = out_q.done;
    assign misaligned_out           = mis_q;
    assign bus_error_out            = berr_q;
endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level model of the load/store rules.
module tb_memory_stage;
    localparam logic [31:0] NOP = 32'h11111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_out;
    logic [31:0] alu_result_in, store_data_in, instruction_bits_in;
    logic [4:0]  rd_in;
    logic        rd_valid_in;
    logic [31:0] program_counter_in, next_program_counter_in;
    logic        done_in;
    logic        dmem_req_out, dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [3:0]  dmem_be_out;
    logic [31:0] dmem_wdata_out, dmem_rdata_in;
    logic        dmem_ack_in;
    logic        wb_valid_out;
    logic [31:0] rd_data_out, source_data_out, instruction_bits_out;
    logic [31:0] program_counter_out, next_program_counter_out;
    logic [4:0]  rd_out;
    logic        rd_valid_out, done_out, misaligned_out, bus_error_out;

    int checks = 0;
    int errors = 0;

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0] alu_op [4] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1100011};

    memory_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .instruction_bits_in(instruction_bits_in), .rd_in(rd_in), .rd_valid_in(rd_valid_in),
        .program_counter_in(program_counter_in), .next_program_counter_in(next_program_counter_in),
        .done_in(done_in), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out), .dmem_be_out(dmem_be_out), .dmem_wdata_out(dmem_wdata_out),
        .dmem_rdata_in(dmem_rdata_in), .dmem_ack_in(dmem_ack_in), .wb_valid_out(wb_valid_out),
        .rd_data_out(rd_data_out), .source_data_out(source_data_out),
        .instruction_bits_out(instruction_bits_out), .program_counter_out(program_counter_out),
        .next_program_counter_out(next_program_counter_out), .rd_out(rd_out),
        .rd_valid_out(rd_valid_out), .done_out(done_out), .misaligned_out(misaligned_out),
        .bus_error_out(bus_error_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // One transaction through the stage; expectations come from the architectural rules.
    task automatic run_txn(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic rdv, input logic [31:0] rdata,
                           input int dly, input bit stray);
        logic [2:0]  f3;
        logic [31:0] pc, npc, exp_rd, exp_be, exp_wd, byte_v, half_v;
        logic        dn;
        bit          is_ld, is_st, mis;
        int          a, size;
        f3    = instr[14:12];
        a     = int'(alu % 4);
        is_ld = (instr[6:0] == 7'b0000011);
        is_st = (instr[6:0] == 7'b0100011);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis   = (is_ld || is_st) && (a % size != 0);
        pc    = $urandom;
        npc   = pc + 4;
        dn    = 1'($urandom);

        @(negedge clk);
        chk("ready_idle", ready_out, 1);
        valid_in = 1'b1; instruction_bits_in = instr; alu_result_in = alu; store_data_in = sd;
        rd_in = rd; rd_valid_in = rdv; program_counter_in = pc; next_program_counter_in = npc;
        done_in = dn;
        @(negedge clk);
        valid_in = 1'b0;
        if (!(is_ld || is_st) || mis) begin
            chk("wb_valid_fast", wb_valid_out, 1);
            chk("rd_data_fast", rd_data_out, alu);
            chk("rd_valid_fast", rd_valid_out, rdv && !(is_ld || is_st));
            chk("instr_fast", instruction_bits_out, instr);
            chk("pc_fast", program_counter_out, pc);
            chk("npc_fast", next_program_counter_out, npc);
            chk("rd_fast", rd_out, rd);
            chk("src_fast", source_data_out, sd);
            chk("done_fast", done_out, dn);
            chk("misaligned", misaligned_out, mis);
            chk("no_req_fast", dmem_req_out, 0);
            if (stray) begin
                dmem_ack_in = 1'b1; dmem_rdata_in = $urandom;
            end
            @(negedge clk);
            dmem_ack_in = 1'b0;
            chk("wb_drop_fast", wb_valid_out, 0);
            chk("nop_fast", instruction_bits_out, NOP);
            chk("mis_pulse_once", misaligned_out, 0);
            chk("idle_after_fast", ready_out, 1);
            chk("no_req_after", dmem_req_out, 0);
        end else begin
            exp_be = (size == 1) ? (32'd1 << a) : (size == 2) ? ((a >= 2) ? 32'd12 : 32'd3) : 32'd15;
            exp_wd = (size == 1) ? (sd % 256) * 32'h01010101 :
                     (size == 2) ? (sd % 65536) * 32'h00010001 : sd;
            for (int i = 0; i <= dly; i++) begin
                chk("req_held", dmem_req_out, 1);
                chk("addr", dmem_addr_out, alu - 32'(a));
                chk("we", dmem_we_out, is_st);
                chk("ready_busy", ready_out, 0);
                chk("wb_busy", wb_valid_out, 0);
                chk("nop_busy", instruction_bits_out, NOP);
                if (is_st) begin
                    chk("be", dmem_be_out, exp_be);
                    chk("wdata", dmem_wdata_out, exp_wd);
                end
                if (i == dly) begin
                    valid_in = 1'b0; dmem_ack_in = 1'b1; dmem_rdata_in = rdata;
                end else begin
                    valid_in = 1'b1;
                end
                @(negedge clk);
            end
            dmem_ack_in = 1'b0;
            dmem_rdata_in = $urandom;
            byte_v = (rdata >> (8 * a)) % 256;
            half_v = (rdata >> (16 * (a / 2))) % 65536;
            if (size == 1)      exp_rd = (f3 == 3'd0 && byte_v >= 128) ? byte_v - 256 : byte_v;
            else if (size == 2) exp_rd = (f3 == 3'd1 && half_v >= 32768) ? half_v - 65536 : half_v;
            else                exp_rd = rdata;
            chk("wb_valid_resp", wb_valid_out, 1);
            if (is_ld) chk("load_data", rd_data_out, exp_rd);
            chk("rd_valid_resp", rd_valid_out, is_ld && rdv);
            chk("instr_resp", instruction_bits_out, instr);
            chk("pc_resp", program_counter_out, pc);
            chk("npc_resp", next_program_counter_out, npc);
            chk("rd_resp", rd_out, rd);
            chk("src_resp", source_data_out, sd);
            chk("done_resp", done_out, dn);
            chk("req_drop", dmem_req_out, 0);
            chk("bus_err_none", bus_error_out, 0);
            @(negedge clk);
            chk("wb_drop_resp", wb_valid_out, 0);
            chk("nop_after_resp", instruction_bits_out, NOP);
            chk("ready_after_resp", ready_out, 1);
        end
    endtask

    initial begin
        logic [31:0] instr;
        int kind;
        rst_n = 1'b0; valid_in = 1'b0; alu_result_in = '0; store_data_in = '0;
        instruction_bits_in = '0; rd_in = '0; rd_valid_in = 1'b0; program_counter_in = '0;
        next_program_counter_in = '0; done_in = 1'b0; dmem_rdata_in = '0; dmem_ack_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", wb_valid_out, 0);
        chk("rst_instr", instruction_bits_out, NOP);
        chk("rst_rd_data", rd_data_out, 0);
        chk("rst_rd_valid", rd_valid_out, 0);
        chk("rst_req", dmem_req_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_pc", program_counter_out, 0);
        chk("rst_mis", misaligned_out, 0);
        chk("rst_berr", bus_error_out, 0);
        rst_n = 1'b1;

        run_txn(32'h00000033, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 1'b0);
        run_txn(32'h00000003, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80FFFF7F, 3, 1'b0);
        run_txn(32'h00001023, 32'h202, 32'h0000ABCD, 5'd3, 1'b1, 32'h0, 1, 1'b0);
        run_txn(32'h00002003, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 0, 1'b0);

        // Reset while waiting on the bus, then a late ack.
        @(negedge clk);
        valid_in = 1'b1; instruction_bits_in = 32'h00002003; alu_result_in = 32'h400;
        @(negedge clk);
        valid_in = 1'b0;
        chk("rstmid_req_before", dmem_req_out, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_drop", dmem_req_out, 0);
        @(negedge clk);
        rst_n = 1'b1; dmem_ack_in = 1'b1; dmem_rdata_in = 32'hDEADBEEF;
        @(negedge clk);
        dmem_ack_in = 1'b0;
        chk("rstmid_wb", wb_valid_out, 0);
        chk("rstmid_idle", ready_out, 1);
        chk("rstmid_req_after", dmem_req_out, 0);
        @(negedge clk);
        chk("rstmid_wb_later", wb_valid_out, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
        @(negedge clk);
        valid_in = 1'b1; instruction_bits_in = 32'h00002003; alu_result_in = 32'h800;
        rd_valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_held", dmem_req_out, 1);
            chk("to_no_err", bus_error_out, 0);
            @(negedge clk);
        end
        chk("to_bus_error", bus_error_out, 1);
        chk("to_wb_valid", wb_valid_out, 1);
        chk("to_rd_data", rd_data_out, 0);
        chk("to_rd_valid", rd_valid_out, 0);
        chk("to_req_drop", dmem_req_out, 0);
        @(negedge clk);
        chk("to_err_pulse", bus_error_out, 0);
`endif

        for (int n = 0; n < 300; n++) begin
            kind  = $urandom_range(0, 2);
            instr = $urandom;
            if (kind == 0) begin
                instr[6:0] = alu_op[$urandom_range(0, 3)];
            end else if (kind == 1) begin
                instr[6:0] = 7'b0000011;
                instr[14:12] = ld_f3[$urandom_range(0, 4)];
            end else begin
                instr[6:0] = 7'b0100011;
                instr[14:12] = 3'($urandom_range(0, 2));
            end
            run_txn(instr, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                    $urandom_range(0, 3), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
